// File: rtl/target_serial_bridge.sv
// target_serial_bridge
//   Target-end responder for the bit-serial bus. It collects a request
//   frame (address, then write data for writes) from the serial bus,
//   issues it to a plain parallel target, waits for the target to finish,
//   returns read data serially, and pulses bus_ack on completion. Only one
//   transaction is in flight at a time, and split transactions are not
//   supported.
//
//   Optional feature macro: TARGET_SERIAL_BRIDGE_TIMEOUT_EN
//     When defined, WAIT_TGT gives up after TIMEOUT_CYCLES cycles. It then
//     pulses timeout_err and returns to IDLE without sending bus_ack.
//     When undefined, WAIT_TGT waits indefinitely and timeout_err stays 0.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   bus_addr_bit(_valid)     serial address bit plus strobe (LSB first)
//   bus_data_bit(_valid)     serial write-data bit plus strobe (LSB first)
//   bus_rw                   1 = write; sampled with the first address bit
//   port_ready               bridge idle; a new frame may start
//   bus_data_out_bit/_valid  serial read data back to the bus
//   bus_ack                  one-cycle completion pulse
//   timeout_err              one-cycle pulse when the target times out
//   target_addr_in(_valid)   parallel address plus one-cycle strobe
//   target_data_in(_valid)   parallel write data plus one-cycle strobe
//   target_rw                direction; held until the bridge is back in IDLE
//   target_data_out(_valid)  read data from the target
//   target_ack               target completion
//   target_ready             target can accept a request
module target_serial_bridge #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bus_addr_bit,
   input  logic                  bus_addr_bit_valid,
   input  logic                  bus_data_bit,
   input  logic                  bus_data_bit_valid,
   input  logic                  bus_rw,
   output logic                  port_ready,
   output logic                  bus_data_out_bit,
   output logic                  bus_data_out_valid,
   output logic                  bus_ack,
   output logic                  timeout_err,
   output logic [ADDR_WIDTH-1:0] target_addr_in,
   output logic                  target_addr_in_valid,
   output logic [DATA_WIDTH-1:0] target_data_in,
   output logic                  target_data_in_valid,
   output logic                  target_rw,
   input  logic [DATA_WIDTH-1:0] target_data_out,
   input  logic                  target_data_out_valid,
   input  logic                  target_ack,
   input  logic                  target_ready
);

   localparam int AC_W = $clog2(ADDR_WIDTH + 1);
   localparam int DC_W = $clog2(DATA_WIDTH + 1);
   localparam logic [AC_W-1:0] ADDR_LAST = AC_W'(ADDR_WIDTH - 1);
   localparam logic [DC_W-1:0] DATA_LAST = DC_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, RX_ADDR, RX_DATA, ISSUE, WAIT_TGT, TX_DATA, ACK
   } state_t;

   state_t                state, state_nx;
   logic [AC_W-1:0]       addr_cnt;
   logic [DC_W-1:0]       data_cnt;   // RX data bit index, then reused for TX
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  ack_seen, data_seen;
   logic                  ack_now, data_now, done;
   logic                  tmo_hit;

   // Completion also counts events arriving in the current cycle, so ack and
   // data may come in either order or together.
   assign ack_now  = ack_seen  | target_ack;
   assign data_now = data_seen | target_data_out_valid;
   assign done     = target_rw ? ack_now : (ack_now & data_now);

`ifdef TARGET_SERIAL_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   // The counter is zero on entry to WAIT_TGT. It fires in the
   // TIMEOUT_CYCLES-th cycle spent there, so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                tmo_cnt <= '0;
      else if (state != WAIT_TGT) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + TW'(1);
   end
   assign tmo_hit = (state == WAIT_TGT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   // Without the feature there is never a timeout. The expression is always
   // false and only keeps the parameter referenced.
   assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx             = state;
      port_ready           = 1'b0;
      target_addr_in_valid = 1'b0;
      target_data_in_valid = 1'b0;
      bus_data_out_valid   = 1'b0;
      bus_ack              = 1'b0;
      timeout_err          = 1'b0;
      case (state)
         IDLE: begin
            port_ready = 1'b1;
            if (bus_addr_bit_valid)
               state_nx = (ADDR_WIDTH == 1) ? (bus_rw ? RX_DATA : ISSUE) : RX_ADDR;
         end
         RX_ADDR:
            if (bus_addr_bit_valid && addr_cnt == ADDR_LAST)
               state_nx = target_rw ? RX_DATA : ISSUE;
         RX_DATA:
            if (bus_data_bit_valid && data_cnt == DATA_LAST)
               state_nx = ISSUE;
         ISSUE:
            if (target_ready) begin
               target_addr_in_valid = 1'b1;
               target_data_in_valid = target_rw;
               state_nx             = WAIT_TGT;
            end
         WAIT_TGT:
            if (done) begin
               // Completion beats a timeout that expires in the same cycle.
               state_nx = target_rw ? ACK : TX_DATA;
            end else if (tmo_hit) begin
               timeout_err = 1'b1;
               state_nx    = IDLE;
            end
         TX_DATA: begin
            bus_data_out_valid = 1'b1;
            if (data_cnt == DATA_LAST) state_nx = ACK;
         end
         ACK: begin
            bus_ack  = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // TX bit select; the output is held low outside TX_DATA.
   always_comb begin
      bus_data_out_bit = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (state == TX_DATA && data_cnt == DC_W'(i)) bus_data_out_bit = rd_data[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_addr_in <= '0;
         target_data_in <= '0;
         target_rw      <= 1'b0;
         addr_cnt       <= '0;
         data_cnt       <= '0;
         rd_data        <= '0;
         ack_seen       <= 1'b0;
         data_seen      <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (bus_addr_bit_valid) begin
                  target_addr_in[0] <= bus_addr_bit;
                  target_rw         <= bus_rw;
                  addr_cnt          <= AC_W'(1);
                  data_cnt          <= '0;
               end
            RX_ADDR:
               if (bus_addr_bit_valid) begin
                  for (int i = 0; i < ADDR_WIDTH; i++)
                     if (addr_cnt == AC_W'(i)) target_addr_in[i] <= bus_addr_bit;
                  addr_cnt <= addr_cnt + AC_W'(1);
               end
            RX_DATA:
               if (bus_data_bit_valid) begin
                  for (int i = 0; i < DATA_WIDTH; i++)
                     if (data_cnt == DC_W'(i)) target_data_in[i] <= bus_data_bit;
                  data_cnt <= data_cnt + DC_W'(1);
               end
            ISSUE:
               if (target_ready) data_cnt <= '0;
            WAIT_TGT:
               if (timeout_err) begin
                  ack_seen  <= 1'b0;
                  data_seen <= 1'b0;
                  addr_cnt  <= '0;
                  target_rw <= 1'b0;
               end else begin
                  if (target_ack) ack_seen <= 1'b1;
                  if (target_data_out_valid) begin
                     data_seen <= 1'b1;
                     rd_data   <= target_data_out;
                  end
               end
            TX_DATA:
               data_cnt <= data_cnt + DC_W'(1);
            ACK: begin
               ack_seen  <= 1'b0;
               data_seen <= 1'b0;
               addr_cnt  <= '0;
               data_cnt  <= '0;
               target_rw <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_target_serial_bridge.sv
// Testbench for target_serial_bridge. Directed and randomized frames are
// checked against expectations derived from the frame contents and the
// target's response timing.
module tb_target_serial_bridge;

   localparam int AW = 16;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          bus_addr_bit, bus_addr_bit_valid;
   logic          bus_data_bit, bus_data_bit_valid;
   logic          bus_rw;
   logic          port_ready, bus_data_out_bit, bus_data_out_valid;
   logic          bus_ack, timeout_err;
   logic [AW-1:0] target_addr_in;
   logic          target_addr_in_valid;
   logic [DW-1:0] target_data_in;
   logic          target_data_in_valid, target_rw;
   logic [DW-1:0] target_data_out;
   logic          target_data_out_valid, target_ack, target_ready;

   always #5 clk = ~clk;

   target_serial_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .bus_addr_bit(bus_addr_bit), .bus_addr_bit_valid(bus_addr_bit_valid),
      .bus_data_bit(bus_data_bit), .bus_data_bit_valid(bus_data_bit_valid),
      .bus_rw(bus_rw), .port_ready(port_ready),
      .bus_data_out_bit(bus_data_out_bit), .bus_data_out_valid(bus_data_out_valid),
      .bus_ack(bus_ack), .timeout_err(timeout_err),
      .target_addr_in(target_addr_in), .target_addr_in_valid(target_addr_in_valid),
      .target_data_in(target_data_in), .target_data_in_valid(target_data_in_valid),
      .target_rw(target_rw), .target_data_out(target_data_out),
      .target_data_out_valid(target_data_out_valid), .target_ack(target_ack),
      .target_ready(target_ready)
   );

   int checks = 0;
   int errors = 0;

   // Monitor log, sampled mid-cycle (negedge + 2).
   int            cyc = 0, n_astb = 0, n_dstb = 0, n_tx = 0, n_ack = 0, n_to = 0;
   int            stb_cyc = 0, tack_cyc = 0, dval_cyc = 0, tx_first = 0, ack_cyc = 0, to_cyc = 0;
   logic [AW-1:0] s_addr = '0;
   logic [DW-1:0] s_data = '0;
   logic          s_rw = 1'b0;
   logic          prev_tx = 1'b0;
   logic          tx_log [4096];

   // Target behaviour: ack / data delays counted from the issue strobe (0 = never).
   int            cfg_ack_dly = 0, cfg_dat_dly = 0;
   logic [DW-1:0] cfg_rdata = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk); #2;
         cyc++;
         if (target_addr_in_valid) begin
            n_astb++; s_addr = target_addr_in; s_rw = target_rw; stb_cyc = cyc;
         end
         if (target_data_in_valid) begin n_dstb++; s_data = target_data_in; end
         if (target_ack) tack_cyc = cyc;
         if (target_data_out_valid) dval_cyc = cyc;
         if (bus_data_out_valid) begin
            if (!prev_tx) tx_first = cyc;
            tx_log[n_tx] = bus_data_out_bit;
            n_tx++;
         end
         prev_tx = bus_data_out_valid;
         if (bus_ack) begin n_ack++; ack_cyc = cyc; end
         if (timeout_err) begin n_to++; to_cyc = cyc; end
      end
   end

   initial begin : target_model
      int ta, td;
      ta = 0; td = 0;
      target_ack = 1'b0; target_data_out_valid = 1'b0; target_data_out = '0;
      forever begin
         @(negedge clk); #1;
         target_ack = 1'b0;
         target_data_out_valid = 1'b0;
         target_data_out = DW'($urandom);   // junk unless valid
         if (ta > 0) begin ta--; if (ta == 0) target_ack = 1'b1; end
         if (td > 0) begin
            td--;
            if (td == 0) begin target_data_out_valid = 1'b1; target_data_out = cfg_rdata; end
         end
         if (target_addr_in_valid) begin ta = cfg_ack_dly; td = cfg_dat_dly; end
      end
   end

   task automatic drive_idle();
      bus_addr_bit_valid = 1'b0; bus_data_bit_valid = 1'b0;
   endtask

   // Serial frame. Stray strobes the bridge must ignore are mixed in:
   // data strobes during address bits, address strobes during data bits,
   // and random bus_rw after the first bit.
   task automatic send_frame(input logic rw, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input bit gap);
      for (int i = 0; i < AW; i++) begin
         if (gap && i > 0) begin @(negedge clk); drive_idle(); bus_rw = 1'($urandom); end
         @(negedge clk);
         bus_addr_bit_valid = 1'b1; bus_addr_bit = addr[i];
         bus_rw = (i == 0) ? rw : 1'($urandom);
         bus_data_bit_valid = 1'($urandom); bus_data_bit = 1'($urandom);
      end
      if (rw) for (int i = 0; i < DW; i++) begin
         if (gap) begin @(negedge clk); drive_idle(); end
         @(negedge clk);
         bus_data_bit_valid = 1'b1; bus_data_bit = data[i];
         bus_addr_bit_valid = 1'($urandom); bus_addr_bit = 1'($urandom);
      end
   endtask

   task automatic run_frame(input string nm, input logic rw, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input bit gap, input int rdy_dly,
                            input int ack_dly, input int dat_dly, input logic [DW-1:0] rdata);
      int a0, d0, t0, k0, o0, lim, done_c;
      logic [DW-1:0] rx;
      cfg_ack_dly = ack_dly; cfg_dat_dly = dat_dly; cfg_rdata = rdata;
      @(negedge clk); drive_idle(); #3;
      chk({nm, ":port_ready_idle"}, port_ready, 1);
      a0 = n_astb; d0 = n_dstb; t0 = n_tx; k0 = n_ack; o0 = n_to;
      target_ready = (rdy_dly == 0);
      send_frame(rw, addr, data, gap);
      // Issue strobe: exactly in the cycle target_ready rises (or right after the last bit).
      for (int c = 0; c <= rdy_dly; c++) begin
         @(negedge clk); drive_idle();
         if (c == rdy_dly) target_ready = 1'b1;
         #3;
         chk({nm, ":addr_strobe"}, target_addr_in_valid, (c == rdy_dly));
         chk({nm, ":data_strobe"}, target_data_in_valid, (c == rdy_dly) && rw);
         chk({nm, ":port_ready_busy"}, port_ready, 0);
      end
      lim = 0;
      while (n_ack == k0 && lim < 300) begin
         @(negedge clk);
         bus_addr_bit_valid = 1'($urandom); bus_addr_bit = 1'($urandom);
         bus_data_bit_valid = 1'($urandom); bus_data_bit = 1'($urandom);
         bus_rw = 1'($urandom);
         #3; lim++;
      end
      chk({nm, ":bus_ack_seen"}, n_ack - k0, 1);
      chk({nm, ":port_ready_in_ack"}, port_ready, 0);
      @(negedge clk); drive_idle(); #3;
      chk({nm, ":port_ready_after"}, port_ready, 1);
      chk({nm, ":ack_one_cycle"}, n_ack - k0, 1);
      chk({nm, ":n_addr_strobes"}, n_astb - a0, 1);
      chk({nm, ":addr"}, s_addr, addr);
      chk({nm, ":rw"}, s_rw, rw);
      chk({nm, ":n_data_strobes"}, n_dstb - d0, rw ? 1 : 0);
      chk({nm, ":n_tx_bits"}, n_tx - t0, rw ? 0 : DW);
      chk({nm, ":no_timeout"}, n_to - o0, 0);
      if (rw) begin
         chk({nm, ":wdata"}, s_data, data);
         chk({nm, ":ack_latency"}, ack_cyc, tack_cyc + 1);
      end else begin
         rx = '0;
         for (int i = 0; i < DW; i++) rx[i] = tx_log[t0 + i];
         chk({nm, ":rdata"}, rx, rdata);
         done_c = (tack_cyc > dval_cyc) ? tack_cyc : dval_cyc;
         chk({nm, ":tx_start"}, tx_first, done_c + 1);
         chk({nm, ":ack_after_tx"}, ack_cyc, done_c + DW + 1);
      end
   endtask

   initial begin : main
      int k0, a0;
      rst_n = 1'b0; target_ready = 1'b0;
      bus_addr_bit = 1'b0; bus_data_bit = 1'b0; bus_rw = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      #3;
      chk("reset:port_ready", port_ready, 1);
      chk("reset:bus_ack", bus_ack, 0);
      chk("reset:tx_valid", bus_data_out_valid, 0);
      chk("reset:addr_valid", target_addr_in_valid, 0);
      chk("reset:target_rw", target_rw, 0);
      chk("reset:target_addr", target_addr_in, 0);
      @(negedge clk); rst_n = 1'b1;

      run_frame("wr_4102", 1'b1, 16'h4102, 8'hD7, 1'b0, 0, 2, 2, 8'h00);
      run_frame("rd_4102", 1'b0, 16'h4102, 8'h00, 1'b0, 0, 2, 2, 8'hD7);
      run_frame("wr_gap",  1'b1, 16'h800A, 8'h5C, 1'b1, 0, 1, 3, 8'h00);
      run_frame("rd_rdy5", 1'b0, 16'h1234, 8'h00, 1'b0, 5, 1, 4, 8'h3C);
      run_frame("rd_ack1", 1'b0, 16'hFFFF, 8'h00, 1'b1, 2, 1, 1, 8'h81);

      // Reset in the middle of an address phase aborts the frame silently.
      cfg_ack_dly = 1; cfg_dat_dly = 1;
      k0 = n_ack; a0 = n_astb;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus_addr_bit_valid = 1'b1; bus_addr_bit = 1'b1; bus_rw = 1'b1;
      end
      @(negedge clk); drive_idle(); rst_n = 1'b0; #3;
      chk("midrst:port_ready", port_ready, 1);
      chk("midrst:target_addr", target_addr_in, 0);
      chk("midrst:target_rw", target_rw, 0);
      chk("midrst:timeout_err", timeout_err, 0);
      @(negedge clk); rst_n = 1'b1; #3;
      chk("midrst:no_ack", n_ack - k0, 0);
      chk("midrst:no_strobe", n_astb - a0, 0);
      run_frame("wr_0011", 1'b1, 16'h0011, 8'hA5, 1'b0, 0, 1, 1, 8'h00);

      for (int n = 0; n < 16; n++) begin
         run_frame($sformatf("rnd%0d", n), 1'($urandom), AW'($urandom), DW'($urandom),
                   1'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                   $urandom_range(1, 4), DW'($urandom));
      end

`ifdef TARGET_SERIAL_BRIDGE_TIMEOUT_EN
      begin : tmo
         int lim, o0;
         cfg_ack_dly = 0; cfg_dat_dly = 0;
         k0 = n_ack; o0 = n_to;
         @(negedge clk); target_ready = 1'b1;
         send_frame(1'b0, 16'h0BAD, 8'h00, 1'b0);
         @(negedge clk); drive_idle(); #3;
         lim = 0;
         while (n_to == o0 && lim < 200) begin @(negedge clk); #3; lim++; end
         chk("tmo:pulse", n_to - o0, 1);
         chk("tmo:at_64", to_cyc, stb_cyc + 64);
         @(negedge clk); #3;
         chk("tmo:one_pulse", n_to - o0, 1);
         chk("tmo:no_ack", n_ack - k0, 0);
         chk("tmo:idle", port_ready, 1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
